// File: rtl/csr_pkg.sv
// csr_pkg: shared encodings for the CSR access unit.
// Zicsr funct3 commands, FSM states and the read-only CSR address prefix.
package csr_pkg;

  localparam logic [2:0] CSR_CMD_RW  = 3'b001;
  localparam logic [2:0] CSR_CMD_RS  = 3'b010;
  localparam logic [2:0] CSR_CMD_RC  = 3'b011;
  localparam logic [2:0] CSR_CMD_RWI = 3'b101;
  localparam logic [2:0] CSR_CMD_RSI = 3'b110;
  localparam logic [2:0] CSR_CMD_RCI = 3'b111;

  // Operation selected by funct3[1:0]; the immediate forms share it.
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  // Top two address bits of a read-only CSR.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_state_t;

  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd == CSR_CMD_RW)  || (cmd == CSR_CMD_RS)  || (cmd == CSR_CMD_RC) ||
           (cmd == CSR_CMD_RWI) || (cmd == CSR_CMD_RSI) || (cmd == CSR_CMD_RCI);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational read-modify step of a Zicsr instruction.
// Produces the new CSR value and whether the instruction must write it back.
module csr_alu
  import csr_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [1:0]          cmd,
  input  logic [WORD_LEN-1:0] old_val,
  input  logic [WORD_LEN-1:0] operand,
  input  logic                src_zero,
  output logic [WORD_LEN-1:0] new_val,
  output logic                write_needed
);

  // Bitwise modify of the old value and the write-back decision.
  always_comb begin
    new_val = '0;
    case (cmd)
      CSR_OP_RW: new_val = operand;
      CSR_OP_RS: new_val = old_val | operand;
      CSR_OP_RC: new_val = old_val & ~operand;
      default:   new_val = '0;
    endcase
    // Set/clear with a zero source field is a pure read.
    write_needed = (cmd == CSR_OP_RW) || !src_zero;
  end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: executes one Zicsr instruction per request as
// read -> modify/write-back -> response against a CSR file with 1-cycle
// registered read latency and synchronous write.
// Optional macro CSR_RO_CHECK_EN: writes to read-only CSRs (addr[11:10]==2'b11)
// are suppressed and reported as illegal.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int WORD_LEN      = 32,
  parameter int REG_ADDR_SIZE = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_cmd,
  input  logic [REG_ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_LEN-1:0]      req_operand,
  input  logic                     req_src_zero,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WORD_LEN-1:0]      resp_rdata,
  output logic                     resp_illegal,
  output logic [REG_ADDR_SIZE-1:0] csr_addr,
  output logic                     csr_wen,
  output logic [WORD_LEN-1:0]      csr_wdata,
  input  logic [WORD_LEN-1:0]      csr_rdata
);

  csr_state_t               state;
  logic [1:0]               cmd_q;
  logic [REG_ADDR_SIZE-1:0] addr_q;
  logic [WORD_LEN-1:0]      operand_q;
  logic                     src_zero_q;

  logic [WORD_LEN-1:0]      alu_new;
  logic                     alu_write;
  logic                     ro_block;
  logic                     wr_fire;

  csr_alu #(
    .WORD_LEN(WORD_LEN)
  ) u_alu (
    .cmd          (cmd_q),
    .old_val      (csr_rdata),
    .operand      (operand_q),
    .src_zero     (src_zero_q),
    .new_val      (alu_new),
    .write_needed (alu_write)
  );

`ifdef CSR_RO_CHECK_EN
  assign ro_block = alu_write && (addr_q[REG_ADDR_SIZE-1 -: 2] == CSR_RO_PREFIX);
`else
  assign ro_block = 1'b0;
`endif

  // The write uses csr_rdata arriving in WRITE, so the strobe is decoded from
  // the registered state rather than registered itself; reset clears it at once.
  assign wr_fire    = (state == ST_WRITE) && alu_write && !ro_block;
  assign csr_wen    = wr_fire;
  assign csr_wdata  = wr_fire ? alu_new : '0;
  assign csr_addr   = addr_q;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // Request sequencing FSM with latched request fields and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      operand_q    <= '0;
      src_zero_q   <= 1'b0;
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q      <= req_cmd[1:0];
            addr_q     <= req_addr;
            operand_q  <= req_operand;
            src_zero_q <= req_src_zero;
            if (!cmd_is_legal(req_cmd)) begin
              resp_illegal <= 1'b1;
              resp_rdata   <= '0;
              state        <= ST_RESP;
            end else begin
              resp_illegal <= 1'b0;
              state        <= ST_READ;
            end
          end
        end
        ST_READ: state <= ST_WRITE;
        ST_WRITE: begin
          if (ro_block) begin
            resp_illegal <= 1'b1;
            resp_rdata   <= '0;
          end else begin
            resp_illegal <= 1'b0;
            resp_rdata   <= csr_rdata;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
